// File: rtl/cycle_sequencer.sv
// cycle_sequencer: fetch/decode/exec/mem/wb instruction-cycle controller with retire counter.
// Optional memory-wait timeout fault compiled in with CYCLE_SEQ_TIMEOUT_EN.
module cycle_sequencer #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_ack,
    input  logic             op_mem,
    input  logic             op_store,
    input  logic             op_wb,
    input  logic             op_halt,
    output logic [2:0]       icycle,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_load,
    output logic             dec_en,
    output logic             alu_en,
    output logic             reg_we,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd7
    } state_t;

    state_t st, nxt;
    logic   mem_q, store_q, wb_q;
    logic   waiting, retire, timeout;

    assign waiting = (st == FETCH) || (st == MEM);

    always_comb begin
        nxt = st;
        case (st)
            FETCH:   nxt = mem_ack ? DECODE : FETCH;
            DECODE:  nxt = op_halt ? HALT : EXEC;
            EXEC:    nxt = mem_q ? MEM : wb_q ? WB : FETCH;
            MEM:     nxt = !mem_ack ? MEM : wb_q ? WB : FETCH;
            WB:      nxt = FETCH;
            default: nxt = HALT;
        endcase
        if (timeout) nxt = HALT;
    end

    assign retire = (nxt == FETCH) && ((st == EXEC) || (st == MEM) || (st == WB));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st          <= FETCH;
            mem_q       <= 1'b0;
            store_q     <= 1'b0;
            wb_q        <= 1'b0;
            instr_count <= '0;
        end else begin
            st <= nxt;
            if (st == DECODE) {mem_q, store_q, wb_q} <= {op_mem, op_store, op_wb};
            if (retire) instr_count <= instr_count + 1'b1;
        end
    end

`ifdef CYCLE_SEQ_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(TIMEOUT_CYCLES);

    logic [WAIT_W-1:0] wait_q;
    logic              fault_q;

    assign timeout = waiting && !mem_ack && (wait_q == LIMIT);

    // Any state change (including the timeout itself) restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            wait_q <= (waiting && !mem_ack && nxt == st) ? wait_q + 1'b1 : '0;
            if (timeout) fault_q <= 1'b1;
        end
    end

    assign fault = fault_q;
`else
    assign timeout = 1'b0;
    assign fault   = 1'b0;
`endif

    assign icycle  = st;
    assign mem_req = waiting;
    assign mem_we  = (st == MEM) && store_q;
    // Gated by reset so every non-request output is quiet while reset is held.
    assign ir_load = (st == FETCH) && mem_ack && reset;
    assign dec_en  = st == DECODE;
    assign alu_en  = st == EXEC;
    assign reg_we  = st == WB;
    assign halted  = st == HALT;
endmodule

// File: tb/tb_cycle_sequencer.sv
// tb_cycle_sequencer: directed self-checking bench for cycle_sequencer.
module tb_cycle_sequencer;
    logic       clk = 1'b0;
    logic       reset, mem_ack, op_mem, op_store, op_wb, op_halt;
    logic [2:0] icycle;
    logic       mem_req, mem_we, ir_load, dec_en, alu_en, reg_we, halted, fault;
    logic [3:0] instr_count;
    int         n_tests = 0;
    int         n_fail  = 0;

    cycle_sequencer #(.TIMEOUT_CYCLES(15), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .mem_ack(mem_ack), .op_mem(op_mem),
        .op_store(op_store), .op_wb(op_wb), .op_halt(op_halt), .icycle(icycle),
        .mem_req(mem_req), .mem_we(mem_we), .ir_load(ir_load), .dec_en(dec_en),
        .alu_en(alu_en), .reg_we(reg_we), .halted(halted), .fault(fault),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic a);
        mem_ack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input logic m, input logic s, input logic w, input logic h);
        {op_mem, op_store, op_wb, op_halt} = {m, s, w, h};
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(1'b0);
        reset = 1'b1;
    endtask

    logic [2:0] awb_seq [4] = '{3'd1, 3'd2, 3'd4, 3'd0};
    logic [2:0] ld_seq  [7] = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
    logic       ld_ack  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int bad, pulses, mems, wes;
        reset = 1'b0;
        mem_ack = 1'b0;
        set_ops(0, 0, 0, 0);
        // Reset held: outputs show FETCH, ack ignored for ir_load.
        repeat (3) step(1'b1);
        check("rst_icycle", 32'(icycle), 0);
        check("rst_mem_req", 32'(mem_req), 1);
        check("rst_others", 32'({mem_we, ir_load, dec_en, alu_en, reg_we, halted, fault}), 0);
        check("rst_count", 32'(instr_count), 0);
        reset = 1'b1;
        bad = 0;
        repeat (3) begin
            step(1'b0);
            if (icycle !== 3'd0 || mem_req !== 1'b1) bad++;
        end
        check("stall_fetch", 32'(bad), 0);
        check("stall_status", 32'({halted, fault, instr_count}), 0);

        // ALU + WB at zero wait.
        do_reset();
        set_ops(0, 0, 1, 0);
        mem_ack = 1'b1;
        #1;
        check("awb_ir_load", 32'(ir_load), 1);
        bad = 0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1);
            if (icycle !== awb_seq[i % 4]) bad++;
            if (reg_we) pulses++;
        end
        check("awb_seq", 32'(bad), 0);
        check("awb_reg_we", 32'(pulses), 3);
        check("awb_count", 32'(instr_count), 3);

        // Load with two MEM wait states.
        do_reset();
        set_ops(1, 0, 1, 0);
        bad = 0;
        pulses = 0;
        mems = 0;
        wes = 0;
        for (int i = 0; i < 7; i++) begin
            step(ld_ack[i]);
            if (icycle !== ld_seq[i]) bad++;
            if (icycle == 3'd3) mems++;
            if (mem_we) wes++;
            if (reg_we) pulses++;
        end
        check("ld_seq", 32'(bad), 0);
        check("ld_mem_cycles", 32'(mems), 3);
        check("ld_mem_we", 32'(wes), 0);
        check("ld_reg_we", 32'(pulses), 1);
        check("ld_count", 32'(instr_count), 1);

        // Store, then HALT.
        do_reset();
        set_ops(1, 1, 0, 0);
        step(1'b1);
        step(1'b1);
        step(1'b1);
        check("st_mem", 32'(icycle), 3);
        check("st_mem_we", 32'(mem_we), 1);
        step(1'b1);
        check("st_count", 32'(instr_count), 1);
        set_ops(0, 0, 1, 1);
        step(1'b1);
        check("hlt_decode", 32'(icycle), 1);
        step(1'b1);
        check("hlt_icycle", 32'(icycle), 7);
        check("hlt_halted", 32'(halted), 1);
        check("hlt_enables", 32'({mem_req, mem_we, ir_load, dec_en, alu_en, reg_we, fault}), 0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            step(i[0]);
            if (icycle !== 3'd7 || instr_count !== 4'd1) bad++;
        end
        check("hlt_frozen", 32'(bad), 0);

        // 4-bit counter wraps.
        do_reset();
        set_ops(0, 0, 0, 0);
        repeat (45) step(1'b1);
        check("wrap_15", 32'(instr_count), 15);
        repeat (3) step(1'b1);
        check("wrap_0", 32'(instr_count), 0);
        repeat (3) step(1'b1);
        check("wrap_1", 32'(instr_count), 1);

`ifdef CYCLE_SEQ_TIMEOUT_EN
        do_reset();
        repeat (15) step(1'b0);
        check("to_before", 32'({halted, fault}), 0);
        step(1'b0);
        check("to_halted", 32'(halted), 1);
        check("to_fault", 32'(fault), 1);
        check("to_icycle", 32'(icycle), 7);
        do_reset();
        check("to_rst_fault", 32'(fault), 0);
        repeat (15) step(1'b0);
        step(1'b1);
        check("to_limit_ack", 32'(icycle), 1);
        check("to_limit_fault", 32'(fault), 0);
`else
        do_reset();
        repeat (40) step(1'b0);
        check("nto_icycle", 32'(icycle), 0);
        check("nto_fault", 32'({halted, fault}), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
